// File: rtl/uart_tx_fifo_reader_if.sv
// rtl/uart_tx_fifo_reader_if.sv - FIFO read port and serial line bundle for uart_tx_fifo_reader
// master is the reader/line driver; slave is the FIFO-and-pad side.
interface uart_tx_fifo_reader_if;
    logic       tx_enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       frame_done;

    modport master (
        input  tx_enable,
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en,
        output tx,
        output busy,
        output frame_done
    );

    modport slave (
        output tx_enable,
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en,
        input  tx,
        input  busy,
        input  frame_done
    );
endinterface

// File: rtl/uart_tx_fifo_reader.sv
// rtl/uart_tx_fifo_reader.sv - pops bytes from the TX FIFO and serializes them as 8N1/8E1 UART frames
module uart_tx_fifo_reader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input logic                  clk,
    input logic                  rst,
    uart_tx_fifo_reader_if.master bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             parity_bit;
    logic             stop_idx;
    logic             bit_end;
    logic             last_stop;

    assign bit_end   = (baud_cnt == CNT_LAST);
    assign last_stop = (stop_idx == STOP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            baud_cnt       <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            parity_bit     <= 1'b0;
            stop_idx       <= 1'b0;
            bus.tx         <= 1'b1;
            bus.fifo_rd_en <= 1'b0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.fifo_rd_en <= 1'b0;
            bus.frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.tx   <= 1'b1;
                    baud_cnt <= '0;
                    if (bus.tx_enable && !bus.fifo_empty) begin
                        bus.fifo_rd_en <= 1'b1;
                        bus.busy       <= 1'b1;
                        state          <= FETCH;
                    end
                end
                // FIFO read data lands one cycle after the pop
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shift      <= bus.fifo_data;
                    parity_bit <= ^bus.fifo_data;
                    baud_cnt   <= '0;
                    bit_idx    <= '0;
                    stop_idx   <= 1'b0;
                    bus.tx     <= 1'b0;
                    state      <= START;
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bus.tx   <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                // tx is preloaded with the next bit so the line changes on the boundary edge
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                bus.tx <= parity_bit;
                                state  <= PARITY;
                            end else begin
                                bus.tx <= 1'b1;
                                state  <= STOP;
                            end
                        end else begin
                            bus.tx <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bus.tx   <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (last_stop && (baud_cnt == CNT_PRE)) begin
                        bus.frame_done <= 1'b1;
                    end
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (last_stop) begin
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// tb/tb_uart_tx_fifo_reader.sv - bench for uart_tx_fifo_reader (8N1 and 8E1/2-stop instances)
module tb_uart_tx_fifo_reader;

    localparam int N = 8;

    logic clk;
    logic rst;
    logic [1:0] en_v;
    logic [1:0] emp_v;
    logic [7:0] dat_v [2];
    logic [1:0] tx_v, busy_v, rd_v, fd_v;

    uart_tx_fifo_reader_if ia ();
    uart_tx_fifo_reader_if ib ();

    uart_tx_fifo_reader #(.CLKS_PER_BIT(N), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    uart_tx_fifo_reader #(.CLKS_PER_BIT(N), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    assign ia.tx_enable  = en_v[0];
    assign ia.fifo_empty = emp_v[0];
    assign ia.fifo_data  = dat_v[0];
    assign ib.tx_enable  = en_v[1];
    assign ib.fifo_empty = emp_v[1];
    assign ib.fifo_data  = dat_v[1];
    assign tx_v   = {ib.tx, ia.tx};
    assign busy_v = {ib.busy, ia.busy};
    assign rd_v   = {ib.fifo_rd_en, ia.fifo_rd_en};
    assign fd_v   = {ib.frame_done, ia.frame_done};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  fq [2][$];
    logic [7:0]  popped [2][$];
    logic [7:0]  rx_q [2][$];
    logic [7:0]  sb [2][$];
    int          start_cyc [2][$];
    int          done_cyc [2][$];
    bit          in_frame [2];
    int          pos [2];
    int          mism [2];
    int          frames [2];
    int          pops [2];
    int          stray_fd [2];
    int          empty_pops [2];
    int          spurious [2];
    logic [7:0]  cur [2];
    logic [11:0] expf [2];
    logic [11:0] obs [2];
    logic [11:0] last_obs [2];

    typedef struct {
        logic [7:0]  data;
        int          dut;
        logic [11:0] exp_bits;
        int          cycles;
    } vec_t;
    vec_t tbl [8];

    // Reference frame: bit k is the k-th bit on the line, start first
    function automatic int frame_len(int i);
        return (i == 1) ? 12 : 10;
    endfunction

    function automatic logic [11:0] frame_bits(int i, logic [7:0] d);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (i == 1) f[9] = ^d;
        return f;
    endfunction

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d);
        fq[i].push_back(d);
        emp_v[i] = 1'b0;
    endtask

    task automatic step();
        int bitn;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rd_v[i] === 1'b1) begin
                pops[i]++;
                if (fq[i].size() == 0) begin
                    empty_pops[i]++;
                end else begin
                    dat_v[i] = fq[i].pop_front();
                    popped[i].push_back(dat_v[i]);
                end
            end
            emp_v[i] = (fq[i].size() == 0);
            if (rst) begin
                in_frame[i] = 1'b0;
            end else begin
                if (!in_frame[i]) begin
                    if (fd_v[i] === 1'b1) stray_fd[i]++;
                    if (tx_v[i] === 1'b0) begin
                        in_frame[i] = 1'b1;
                        pos[i]      = 0;
                        mism[i]     = 0;
                        obs[i]      = '1;
                        start_cyc[i].push_back(cyc);
                        if (popped[i].size() == 0) begin
                            spurious[i]++;
                            cur[i] = 8'h00;
                        end else begin
                            cur[i] = popped[i].pop_front();
                        end
                        expf[i] = frame_bits(i, cur[i]);
                    end
                end
                if (in_frame[i]) begin
                    bitn = pos[i] / N;
                    if (tx_v[i] !== expf[i][bitn]) mism[i]++;
                    if (fd_v[i] !== (pos[i] == frame_len(i) * N - 1)) mism[i]++;
                    if (busy_v[i] !== 1'b1) mism[i]++;
                    if (pos[i] % N == N / 2) obs[i][bitn] = tx_v[i];
                    pos[i]++;
                    if (pos[i] == frame_len(i) * N) begin
                        in_frame[i] = 1'b0;
                        check(mism[i] == 0, "frame_waveform", mism[i], 0);
                        last_obs[i] = obs[i];
                        rx_q[i].push_back(obs[i][8:1]);
                        done_cyc[i].push_back(cyc);
                        frames[i]++;
                    end
                end
            end
        end
    endtask

    task automatic wait_frames(input int i, input int target, input int budget, input string name);
        int n;
        n = 0;
        while (frames[i] < target && n < budget) begin
            step();
            n++;
        end
        check(frames[i] >= target, name, frames[i], target);
    endtask

    task automatic wait_pos(input int i, input int p, input int budget, input string name);
        int n;
        n = 0;
        while (!(in_frame[i] && pos[i] >= p) && n < budget) begin
            step();
            n++;
        end
        check(in_frame[i] && pos[i] >= p, name, pos[i], p);
    endtask

    initial begin
        int p0, f0, s0, sz, n;
        logic [7:0] b;

        tbl[0] = '{8'hA5, 0, 12'b11_1_10100101_0, 80};
        tbl[1] = '{8'h00, 0, 12'b11_1_00000000_0, 80};
        tbl[2] = '{8'hFF, 0, 12'b11_1_11111111_0, 80};
        tbl[3] = '{8'h3C, 0, 12'b11_1_00111100_0, 80};
        tbl[4] = '{8'h07, 1, 12'b11_1_00000111_0, 96};
        tbl[5] = '{8'h80, 1, 12'b11_1_10000000_0, 96};
        tbl[6] = '{8'hC3, 1, 12'b11_0_11000011_0, 96};
        tbl[7] = '{8'h3C, 1, 12'b11_0_00111100_0, 96};

        rst   = 1'b1;
        en_v  = 2'b00;
        emp_v = 2'b11;
        dat_v[0] = 8'h00;
        dat_v[1] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            in_frame[i] = 1'b0;
            pos[i] = 0; mism[i] = 0; frames[i] = 0; pops[i] = 0;
            stray_fd[i] = 0; empty_pops[i] = 0; spurious[i] = 0;
            cur[i] = '0; expf[i] = '1; obs[i] = '1; last_obs[i] = '1;
        end

        // Reset held with a non-empty FIFO
        push(0, 8'h11);
        for (int k = 0; k < 3; k++) begin
            step();
            check(tx_v[0] === 1'b1, "reset_tx", tx_v[0], 1);
            check(busy_v[0] === 1'b0, "reset_busy", busy_v[0], 0);
            check(rd_v[0] === 1'b0, "reset_rd_en", rd_v[0], 0);
        end
        rst = 1'b0;
        repeat (20) step();
        check(pops[0] == 0, "no_pop_when_disabled", pops[0], 0);
        check(tx_v[0] === 1'b1, "idle_tx_high", tx_v[0], 1);
        fq[0].delete();
        emp_v[0] = 1'b1;

        // Single frames against hand-built line patterns
        for (int t = 0; t < 8; t++) begin
            int i;
            i  = tbl[t].dut;
            p0 = pops[i];
            f0 = frames[i];
            push(i, tbl[t].data);
            en_v[i] = 1'b1;
            wait_frames(i, f0 + 1, 300, "table_frame_timeout");
            en_v[i] = 1'b0;
            sz = start_cyc[i].size();
            check(last_obs[i] == tbl[t].exp_bits, "table_line_bits", last_obs[i], tbl[t].exp_bits);
            check(done_cyc[i][sz-1] - start_cyc[i][sz-1] + 1 == tbl[t].cycles, "table_frame_len",
                  done_cyc[i][sz-1] - start_cyc[i][sz-1] + 1, tbl[t].cycles);
            check(pops[i] - p0 == 1, "table_one_pop", pops[i] - p0, 1);
            repeat (4) step();
        end

        // Back-to-back frames, minimum gap
        p0 = pops[0];
        f0 = frames[0];
        push(0, 8'h00); push(0, 8'hFF); push(0, 8'h3C);
        en_v[0] = 1'b1;
        wait_frames(0, f0 + 3, 600, "b2b_timeout");
        sz = start_cyc[0].size();
        check(pops[0] - p0 == 3, "b2b_pops", pops[0] - p0, 3);
        check(rx_q[0][rx_q[0].size()-3] == 8'h00, "b2b_byte0", rx_q[0][rx_q[0].size()-3], 8'h00);
        check(rx_q[0][rx_q[0].size()-2] == 8'hFF, "b2b_byte1", rx_q[0][rx_q[0].size()-2], 8'hFF);
        check(rx_q[0][rx_q[0].size()-1] == 8'h3C, "b2b_byte2", rx_q[0][rx_q[0].size()-1], 8'h3C);
        check(start_cyc[0][sz-2] - done_cyc[0][sz-3] == 4, "b2b_gap1",
              start_cyc[0][sz-2] - done_cyc[0][sz-3], 4);
        check(start_cyc[0][sz-1] - done_cyc[0][sz-2] == 4, "b2b_gap2",
              start_cyc[0][sz-1] - done_cyc[0][sz-2], 4);
        repeat (30) step();
        check(pops[0] - p0 == 3, "b2b_no_pop_when_empty", pops[0] - p0, 3);
        en_v[0] = 1'b0;

        // Reset during data bit 3 of 0x55
        p0 = pops[0];
        push(0, 8'h55); push(0, 8'h96);
        en_v[0] = 1'b1;
        wait_pos(0, 4 * N + 4, 200, "midreset_reach_bit3");
        rst = 1'b1;
        step();
        check(tx_v[0] === 1'b1, "midreset_tx", tx_v[0], 1);
        check(busy_v[0] === 1'b0, "midreset_busy", busy_v[0], 0);
        check(fd_v[0] === 1'b0, "midreset_frame_done", fd_v[0], 0);
        rst = 1'b0;
        f0 = frames[0];
        wait_frames(0, f0 + 1, 300, "midreset_next_timeout");
        check(rx_q[0][rx_q[0].size()-1] == 8'h96, "midreset_next_byte", rx_q[0][rx_q[0].size()-1], 8'h96);
        check(pops[0] - p0 == 2, "midreset_pops", pops[0] - p0, 2);
        en_v[0] = 1'b0;
        repeat (4) step();

        // tx_enable dropped during START with two bytes queued
        push(0, 8'h5A); push(0, 8'hC3);
        en_v[0] = 1'b1;
        wait_pos(0, 3, 100, "endrop_reach_start");
        en_v[0] = 1'b0;
        p0 = pops[0];
        f0 = frames[0];
        wait_frames(0, f0 + 1, 200, "endrop_finish_timeout");
        check(rx_q[0][rx_q[0].size()-1] == 8'h5A, "endrop_current_byte", rx_q[0][rx_q[0].size()-1], 8'h5A);
        s0 = start_cyc[0].size();
        repeat (40) step();
        check(pops[0] == p0, "endrop_no_pop", pops[0] - p0, 0);
        check(start_cyc[0].size() == s0, "endrop_no_start", start_cyc[0].size() - s0, 0);
        en_v[0] = 1'b1;
        wait_frames(0, f0 + 2, 300, "endrop_resume_timeout");
        check(rx_q[0][rx_q[0].size()-1] == 8'hC3, "endrop_resume_byte", rx_q[0][rx_q[0].size()-1], 8'hC3);
        en_v[0] = 1'b0;
        repeat (4) step();

        // Random traffic on both instances against the byte scoreboard
        rx_q[0].delete(); rx_q[1].delete();
        for (int it = 0; it < 30; it++) begin
            int i;
            i = $urandom_range(0, 1);
            repeat ($urandom_range(1, 3)) begin
                b = 8'($urandom);
                push(i, b);
                sb[i].push_back(b);
            end
            en_v[0] = ($urandom_range(0, 3) != 0);
            en_v[1] = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(10, 150)) step();
        end
        en_v = 2'b11;
        n = 0;
        while ((rx_q[0].size() < sb[0].size() || rx_q[1].size() < sb[1].size()) && n < 30000) begin
            step();
            n++;
        end
        for (int i = 0; i < 2; i++) begin
            check(rx_q[i].size() == sb[i].size(), "rand_frame_count", rx_q[i].size(), sb[i].size());
            for (int k = 0; k < sb[i].size() && k < rx_q[i].size(); k++)
                check(rx_q[i][k] == sb[i][k], "rand_byte", rx_q[i][k], sb[i][k]);
            check(stray_fd[i] == 0, "stray_frame_done", stray_fd[i], 0);
            check(empty_pops[i] == 0, "pop_while_empty", empty_pops[i], 0);
            check(spurious[i] == 0, "start_without_pop", spurious[i], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
